// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input path: default debounce length and idle levels.
// Package only; no logic, latency or flow control.
package gpio_pkg;

    localparam int   GPIO_DEBOUNCE_DEFAULT = 500000;  // 10 ms at 50 MHz
    localparam logic KEY_RELEASED          = 1'b1;    // keys are active-low
    localparam logic SWITCH_RESET          = 1'b0;

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchroniser plus hold counter; accepts a level after DEBOUNCE_CYCLES samples.
// Latency 1+DEBOUNCE_CYCLES edges after first sample; no backpressure, outputs valid every cycle.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
    parameter logic RESET_LEVEL     = SWITCH_RESET
) (
    input  logic CoreClock,
    input  logic CoreReset_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge CoreClock or negedge CoreReset_n) begin
        if (!CoreReset_n) begin
            sync1  <= RESET_LEVEL;
            sync2  <= RESET_LEVEL;
            stable <= RESET_LEVEL;
            cnt    <= '0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync1  <= i_raw;
            sync2  <= sync1;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Edge pulses are registered alongside the level so they line up with o_stable.
                stable <= sync2;
                cnt    <= '0;
                o_rise <= sync2;
                o_fall <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_stable = stable;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Synchronises and debounces board switches and active-low keys, with per-key press/release pulses.
// Latency 1+DEBOUNCE_CYCLES edges; no handshake, all outputs registered and sampled every cycle.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int NUM_SWITCHES    = 10,
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT
) (
    input  logic                    CoreClock,
    input  logic                    CoreReset_n,
    input  logic [NUM_SWITCHES-1:0] i_Switches,
    input  logic [NUM_KEYS-1:0]     i_Keys,
    output logic [NUM_SWITCHES-1:0] o_Switches,
    output logic [NUM_KEYS-1:0]     o_Keys,
    output logic [NUM_KEYS-1:0]     o_KeyPressed,
    output logic [NUM_KEYS-1:0]     o_KeyReleased
);

    // Switches carry no events; their edge outputs terminate here.
    logic [NUM_SWITCHES-1:0] sw_rise_unused;
    logic [NUM_SWITCHES-1:0] sw_fall_unused;

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (SWITCH_RESET)
        ) u_sw (
            .CoreClock   (CoreClock),
            .CoreReset_n (CoreReset_n),
            .i_raw       (i_Switches[i]),
            .o_stable    (o_Switches[i]),
            .o_rise      (sw_rise_unused[i]),
            .o_fall      (sw_fall_unused[i])
        );
    end

    // Active-low keys: a falling level is a press, a rising level a release.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (KEY_RELEASED)
        ) u_key (
            .CoreClock   (CoreClock),
            .CoreReset_n (CoreReset_n),
            .i_raw       (i_Keys[i]),
            .o_stable    (o_Keys[i]),
            .o_rise      (o_KeyReleased[i]),
            .o_fall      (o_KeyPressed[i])
        );
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboarded bench: a sliding-window reference model predicts every cycle's outputs into a queue.
// Directed test-plan scenarios plus randomised toggling and reset pulses.
module tb_gpio_input_conditioner;

    localparam int NS = 10;
    localparam int NK = 4;
    localparam int D  = 4;
    localparam int NB = NS + NK;

    logic          CoreClock   = 1'b0;
    logic          CoreReset_n = 1'b0;
    logic [NS-1:0] i_Switches  = '0;
    logic [NK-1:0] i_Keys      = '1;
    logic [NS-1:0] o_Switches;
    logic [NK-1:0] o_Keys;
    logic [NK-1:0] o_KeyPressed;
    logic [NK-1:0] o_KeyReleased;

    gpio_input_conditioner #(
        .NUM_SWITCHES    (NS),
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CoreClock     (CoreClock),
        .CoreReset_n   (CoreReset_n),
        .i_Switches    (i_Switches),
        .i_Keys        (i_Keys),
        .o_Switches    (o_Switches),
        .o_Keys        (o_Keys),
        .o_KeyPressed  (o_KeyPressed),
        .o_KeyReleased (o_KeyReleased)
    );

    always #5 CoreClock = ~CoreClock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each bit keeps the raw values it sampled; the output adopts a new level once the
    // D samples that have crossed the synchroniser all disagree with the current output.
    typedef struct packed {
        logic [NS-1:0] sw;
        logic [NK-1:0] keys;
        logic [NK-1:0] pressed;
        logic [NK-1:0] released;
    } exp_t;

    exp_t sb_q[$];
    logic m_stable [NB];
    logic hist     [NB][$];

    function automatic logic idle_level(int b);
        return (b >= NS);
    endfunction

    task automatic reset_model();
        for (int b = 0; b < NB; b++) begin
            m_stable[b] = idle_level(b);
            hist[b].delete();
            hist[b].push_back(idle_level(b));
            hist[b].push_back(idle_level(b));
        end
    endtask

    function automatic exp_t model_out(input logic [NK-1:0] pr, input logic [NK-1:0] rl);
        exp_t e;
        for (int b = 0; b < NS; b++) e.sw[b] = m_stable[b];
        for (int b = 0; b < NK; b++) e.keys[b] = m_stable[NS+b];
        e.pressed  = pr;
        e.released = rl;
        return e;
    endfunction

    always @(negedge CoreReset_n) begin
        reset_model();
        sb_q.delete();
    end

    always @(posedge CoreClock) begin
        logic [NB-1:0] raw;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        int            n;
        logic          upd;
        pr = '0;
        rl = '0;
        if (!CoreReset_n) begin
            reset_model();
        end else begin
            raw = {i_Keys, i_Switches};
            for (int b = 0; b < NB; b++) begin
                n   = hist[b].size();
                upd = (n >= D + 1);
                for (int k = n - 1 - D; k <= n - 2; k++)
                    if (k >= 0 && hist[b][k] == m_stable[b]) upd = 1'b0;
                if (upd) begin
                    m_stable[b] = ~m_stable[b];
                    if (b >= NS) begin
                        if (m_stable[b]) rl[b-NS] = 1'b1;
                        else             pr[b-NS] = 1'b1;
                    end
                end
                hist[b].push_back(raw[b]);
                if (hist[b].size() > D + 3) void'(hist[b].pop_front());
            end
        end
        sb_q.push_back(model_out(pr, rl));
    end

    // ---------------- monitor ----------------
    int press2_cnt = 0;

    always @(negedge CoreClock) begin
        exp_t e;
        if (o_KeyPressed[2]) press2_cnt++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("o_Switches",    32'(o_Switches),    32'(e.sw));
            check("o_Keys",        32'(o_Keys),        32'(e.keys));
            check("o_KeyPressed",  32'(o_KeyPressed),  32'(e.pressed));
            check("o_KeyReleased", 32'(o_KeyReleased), 32'(e.released));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [NS-1:0] sw, input logic [NK-1:0] k);
        @(posedge CoreClock);
        #1;
        i_Switches = sw;
        i_Keys     = k;
    endtask

    task automatic hold(input int n);
        repeat (n) drive(i_Switches, i_Keys);
    endtask

    task automatic pulse_reset(input int n, input bit scramble);
        @(posedge CoreClock);
        #1;
        CoreReset_n = 1'b0;
        if (scramble) begin
            i_Switches = NS'($urandom);
            i_Keys     = NK'($urandom);
        end
        #1;
        check("rst_sw",   32'(o_Switches),    32'h0);
        check("rst_keys", 32'(o_Keys),        32'hF);
        check("rst_prs",  32'(o_KeyPressed),  32'h0);
        check("rst_rls",  32'(o_KeyReleased), 32'h0);
        repeat (n) @(posedge CoreClock);
        #1;
        CoreReset_n = 1'b1;
    endtask

    initial begin
        pulse_reset(3, 1'b1);
        drive('0, 4'hF);
        hold(8);

        // Clean press: first sampled at edge t, output at t+5, pulse for one cycle.
        drive('0, 4'hE);
        repeat (5) @(posedge CoreClock);
        #1;
        check("press_early", 32'(o_Keys), 32'hF);
        @(posedge CoreClock);
        #1;
        check("press_keys",  32'(o_Keys),       32'hE);
        check("press_pulse", 32'(o_KeyPressed), 32'h1);
        @(posedge CoreClock);
        #1;
        check("press_once",  32'(o_KeyPressed), 32'h0);
        hold(6);
        drive('0, 4'hF);
        hold(10);

        // Glitch of 3 samples on switch 3 is rejected; 4 samples are accepted.
        drive(10'h008, 4'hF);
        hold(2);
        drive('0, 4'hF);
        hold(8);
        check("glitch_sw", 32'(o_Switches), 32'h0);
        drive(10'h008, 4'hF);
        hold(3);
        drive('0, 4'hF);
        hold(10);

        // Bounce on key 2 gives exactly one press.
        press2_cnt = 0;
        drive('0, 4'hB); drive('0, 4'hF); drive('0, 4'hB); drive('0, 4'hF);
        drive('0, 4'hB);
        hold(10);
        check("bounce_presses", 32'(press2_cnt), 32'd1);
        drive('0, 4'hF);
        hold(10);

        // All keys at once.
        drive('0, 4'h0);
        hold(10);
        drive('0, 4'hF);
        hold(10);

        // Reset mid-count with the key held through it.
        drive('0, 4'hE);
        repeat (3) @(posedge CoreClock);
        pulse_reset(2, 1'b0);
        hold(10);
        drive('0, 4'hF);
        hold(10);

        // Randomised toggling with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [NS-1:0] sw;
            logic [NK-1:0] k;
            sw = i_Switches;
            k  = i_Keys;
            for (int b = 0; b < NS; b++) if ($urandom_range(7) == 0) sw[b] = ~sw[b];
            for (int b = 0; b < NK; b++) if ($urandom_range(7) == 0) k[b] = ~k[b];
            if ($urandom_range(499) == 0) pulse_reset($urandom_range(1, 3), 1'b0);
            drive(sw, k);
        end
        hold(12);

        @(negedge CoreClock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
